// File: rtl/calc_seq_requant.sv
// Per-pixel calc sequencer for the 3-slice partial-sum collector, plus the
// requantizer that turns the collector's 21-bit sum into an 8-bit result.
module calc_seq_requant #(
   parameter int CNT_W    = 7,
   parameter int CNT_LAST = 69,
   parameter int ACC_W    = 21,
   parameter int SCALE_W  = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               data_vld,
   input  logic [ACC_W-1:0]   bias,
   input  logic [SCALE_W-1:0] scale,
   input  logic [4:0]         shift,
   input  logic               relu_en,
   input  logic [ACC_W-1:0]   sum_all,
   output logic [CNT_W-1:0]   cnt,
   output logic               in_vld,
   output logic [7:0]         compress,
   output logic               busy,
   output logic               done
);

   localparam int PROD_W = ACC_W + SCALE_W + 2;
   localparam int R_W    = PROD_W + 1;

   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(CNT_LAST);
   localparam logic [CNT_W-1:0] CNT_TAIL = CNT_W'(CNT_LAST - 1);
   localparam logic [CNT_W-1:0] CNT_BEAT = CNT_W'(CNT_LAST - 2);

   localparam logic signed [R_W-1:0] R_ONE  = {{(R_W-1){1'b0}}, 1'b1};
   localparam logic signed [R_W-1:0] R_ZERO = {R_W{1'b0}};
   localparam logic signed [R_W-1:0] SAT_HI = {{(R_W-7){1'b0}}, 7'h7f};
   localparam logic signed [R_W-1:0] SAT_LO = {{(R_W-7){1'b1}}, 7'h00};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      TAIL = 2'd2
   } state_t;

   state_t                    state_r, state_s;
   logic [CNT_W-1:0]          cnt_r, cnt_s;
   logic                      in_vld_s, load_s, prod_en_s;
   logic [ACC_W-1:0]          bias_r;
   logic [SCALE_W-1:0]        scale_r;
   logic [4:0]                shift_r;
   logic                      relu_r;
   logic signed [PROD_W-1:0]  prod_r;

   logic signed [ACC_W:0]     pre_s;
   logic signed [SCALE_W:0]   scale_x_s;
   logic signed [PROD_W-1:0]  prod_s;
   logic signed [R_W-1:0]     round_s, sum_s, r_s, lo_s;
   logic [7:0]                comp_s;

   // Next-state, counter and handshake decode
   always_comb begin
      state_s   = state_r;
      cnt_s     = cnt_r;
      in_vld_s  = 1'b0;
      load_s    = 1'b0;
      prod_en_s = 1'b0;
      case (state_r)
         IDLE: begin
            cnt_s = '0;
            if (start) begin
               state_s = RUN;
               load_s  = 1'b1;
            end else begin
               state_s = IDLE;
            end
         end
         RUN: begin
            in_vld_s = data_vld;
            if (data_vld && (cnt_r == CNT_BEAT)) begin
               cnt_s   = CNT_TAIL;
               state_s = TAIL;
            end else if (data_vld) begin
               cnt_s = cnt_r + CNT_ONE;
            end else begin
               cnt_s = cnt_r;
            end
         end
         TAIL: begin
            prod_en_s = (cnt_r == CNT_TAIL);
            if (cnt_r == CNT_END) begin
               state_s = IDLE;
               cnt_s   = '0;
            end else begin
               cnt_s = cnt_r + CNT_ONE;
            end
         end
         default: begin
            state_s = IDLE;
            cnt_s   = '0;
         end
      endcase
   end

   // Sequencer state, job configuration and stage-1 product registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         cnt_r   <= '0;
         bias_r  <= '0;
         scale_r <= '0;
         shift_r <= 5'd0;
         relu_r  <= 1'b0;
         prod_r  <= '0;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         if (load_s) begin
            bias_r  <= bias;
            scale_r <= scale;
            shift_r <= shift;
            relu_r  <= relu_en;
         end
         if (prod_en_s) begin
            prod_r <= prod_s;
         end
      end
   end

   assign pre_s     = $signed({sum_all[ACC_W-1], sum_all}) + $signed({bias_r[ACC_W-1], bias_r});
   assign scale_x_s = $signed({1'b0, scale_r});
   assign prod_s    = PROD_W'(pre_s) * PROD_W'(scale_x_s);

   // Half-up rounding shift; the extra bit keeps the rounding add from overflowing
   assign round_s = (shift_r != 5'd0) ? (R_ONE <<< (shift_r - 5'd1)) : R_ZERO;
   assign sum_s   = R_W'(prod_r) + round_s;
   assign r_s     = sum_s >>> shift_r;
   assign lo_s    = relu_r ? R_ZERO : SAT_LO;

   // Saturate to the signed 8-bit range, lower bound raised to 0 under ReLU
   always_comb begin
      comp_s = 8'h00;
      if (r_s > SAT_HI) begin
         comp_s = 8'h7f;
      end else if (r_s < lo_s) begin
         comp_s = lo_s[7:0];
      end else begin
         comp_s = r_s[7:0];
      end
   end

   assign cnt      = cnt_r;
   assign in_vld   = in_vld_s;
   assign compress = comp_s;
   assign busy     = (state_r != IDLE);
   assign done     = (state_r == TAIL) && (cnt_r == CNT_END);

endmodule
